// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared boot loader state type, sync default and state helpers
package boot_loader_pkg;

  localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    CHK     = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } boot_state_t;

  // States in which the loader is willing to take a byte from the host.
  function automatic logic boot_accepts(boot_state_t s);
    return (s == IDLE) || (s == LEN_HI) || (s == LEN_LO) ||
           (s == DATA_HI) || (s == DATA_LO) || (s == CHK);
  endfunction

  // States whose bytes are length/data payload (packed into words, summed).
  function automatic logic boot_is_payload(boot_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
  endfunction

endpackage

// File: rtl/boot_byte_pack.sv
// rtl/boot_byte_pack.sv - pairs handshaked bytes into a big-endian 16-bit word
module boot_byte_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_en,
  output logic [15:0] word,
  output logic [15:0] word_next
);

  logic       phase_q;
  logic [7:0] hi_q;
  logic [7:0] lo_q;

  // Alternate hi/lo capture; clear realigns to the hi phase between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
    end else if (clear) begin
      phase_q <= 1'b0;
    end else if (byte_en) begin
      if (!phase_q) begin
        hi_q <= byte_data;
      end else begin
        lo_q <= byte_data;
      end
      phase_q <= ~phase_q;
    end
  end

  assign word      = {hi_q, lo_q};
  // Word as it will look once the byte currently offered is taken as lo.
  assign word_next = {hi_q, byte_data};

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - host byte-stream boot loader into instruction memory (option macro BOOT_CHECKSUM_EN)
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = BOOT_SYNC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              im_we,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t END_STATE = CHK;
`else
  localparam boot_state_t END_STATE = DONE;
`endif

  boot_state_t   state_q;
  boot_state_t   state_d;
  logic          armed_q;
  logic [15:0]   n_q;
  logic [ADDR_W:0] idx_q;
  logic [16:0]   idx_inc;
  logic          last_word;
  logic          fire;
  logic          payload_en;
  logic [15:0]   word;
  logic [15:0]   word_next;

  assign fire       = in_valid && in_ready;
  assign payload_en = fire && boot_is_payload(state_q);
  assign idx_inc    = 17'(idx_q) + 17'd1;
  assign last_word  = (idx_inc == {1'b0, n_q});

  boot_byte_pack u_pack (
    .clk       (CLK),
    .rst_n     (RST),
    .clear     (state_q == IDLE),
    .byte_data (in_data),
    .byte_en   (payload_en),
    .word      (word),
    .word_next (word_next)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running mod-256 sum of every length and data byte taken from the host.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sum_q <= 8'h00;
    end else if (payload_en) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  // Next-state decode; every transition except WRITE waits on a handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire && (in_data == SYNC_BYTE)) state_d = LEN_HI;
      LEN_HI:  if (fire) state_d = LEN_LO;
      LEN_LO: begin
        if (fire) begin
          if (word_next == 16'h0000) begin
            state_d = END_STATE;
          end else if ({1'b0, word_next} > MAX_WORDS) begin
            state_d = ERROR;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: if (fire) state_d = DATA_LO;
      DATA_LO: if (fire) state_d = WRITE;
      WRITE:   state_d = last_word ? END_STATE : DATA_HI;
`ifdef BOOT_CHECKSUM_EN
      CHK:     if (fire) state_d = (in_data == sum_q) ? DONE : ERROR;
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // State, length capture and word index; armed_q delays in_ready one edge past reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      n_q     <= 16'h0000;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (fire && (state_q == LEN_LO)) begin
        n_q <= word_next;
      end
      if (state_q == WRITE) begin
        idx_q <= idx_q + (ADDR_W+1)'(1);
      end
    end
  end

  assign in_ready  = armed_q && boot_accepts(state_q);
  assign im_we     = (state_q == WRITE);
  assign im_addr   = idx_q[ADDR_W-1:0];
  assign im_wdata  = word;
  assign cpu_rst_n = (state_q == DONE);
  assign boot_done = (state_q == DONE);
  assign boot_err  = (state_q == ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
module tb_boot_loader;

  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;
  logic              im_we;
  logic              cpu_rst_n;
  logic              boot_done;
  logic              boot_err;

  boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .im_we     (im_we),
    .cpu_rst_n (cpu_rst_n),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors = 0;
  int wr_count = 0;
  int ready_bad = 0;
  int seq_bad = 0;
  logic [ADDR_W-1:0] wr_addr [0:1023];
  logic [15:0]       wr_data [0:1023];
  logic [7:0]        tb_sum;

  // Write monitor sampled on the falling edge, away from state updates.
  always @(negedge CLK) begin
    if (im_we) begin
      if (wr_count < 1024) begin
        wr_addr[wr_count] = im_addr;
        wr_data[wr_count] = im_wdata;
      end
      if (in_ready) ready_bad++;
      if (im_addr != wr_count[ADDR_W-1:0]) seq_bad++;
      wr_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge CLK);
    end
    in_data  = b;
    in_valid = 1'b1;
    for (t = 0; t < 50; t++) begin
      if (in_ready) break;
      @(negedge CLK);
    end
    if (!in_ready) chk("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] b, input bit gap);
    tb_sum = tb_sum + b;
    send_byte(b, gap);
  endtask

  task automatic wait_end(input int max_cycles);
    for (int t = 0; t < max_cycles; t++) begin
      if (boot_done || boot_err) break;
      @(negedge CLK);
    end
    chk("end_reached", 32'(boot_done | boot_err), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    wr_count = 0;
    ready_bad = 0;
    seq_bad = 0;
    #2 RST = 1'b1;
    @(negedge CLK);
  endtask

  // Two-word frame 00 02 / 1234 / ABCD; trailing checksum only in checksum builds.
  task automatic send_frame(input bit gaps, input logic [7:0] sum_adj);
    tb_sum = 8'h00;
    send_byte(8'hA5, gaps && ($urandom_range(0, 1) != 0));
    send_payload(8'h00, gaps && ($urandom_range(0, 1) != 0));
    send_payload(8'h02, gaps && ($urandom_range(0, 1) != 0));
    send_payload(8'h12, gaps && ($urandom_range(0, 1) != 0));
    send_payload(8'h34, gaps && ($urandom_range(0, 1) != 0));
    send_payload(8'hAB, gaps && ($urandom_range(0, 1) != 0));
    send_payload(8'hCD, gaps && ($urandom_range(0, 1) != 0));
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_sum + sum_adj, gaps);
`else
    if (sum_adj != 8'h00) send_byte(sum_adj, gaps);
`endif
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'd2);
    chk({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0);
    chk({tag, "_data0"}, 32'(wr_data[0]), 32'h1234);
    chk({tag, "_addr1"}, 32'(wr_addr[1]), 32'h1);
    chk({tag, "_data1"}, 32'(wr_data[1]), 32'hABCD);
    chk({tag, "_done"}, 32'(boot_done), 32'd1);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    chk({tag, "_err"}, 32'(boot_err), 32'd0);
    chk({tag, "_ready_in_done"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] last_w;

    // Reset values while RST is held low.
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_boot_err", 32'(boot_err), 32'd0);
    #2 RST = 1'b1;
    #1 chk("ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge CLK);
    #1 chk("ready_after_first_edge", 32'(in_ready), 32'd1);
    @(negedge CLK);

    // Junk bytes before sync, then the basic two-word frame.
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_frame(1'b0, 8'h00);
    wait_end(20);
    check_two_words("basic");
    chk("basic_ready_on_write", 32'(ready_bad), 32'd0);

    // Same frame with random valid gaps.
    do_reset();
    send_frame(1'b1, 8'h00);
    wait_end(40);
    check_two_words("gapped");
    chk("gapped_ready_on_write", 32'(ready_bad), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Checksum off by one -> error.
    do_reset();
    send_frame(1'b0, 8'h01);
    wait_end(20);
    chk("badsum_err", 32'(boot_err), 32'd1);
    chk("badsum_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("badsum_in_ready", 32'(in_ready), 32'd0);
`endif

    // Length 1025 exceeds memory -> error, no writes.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_end(20);
    chk("toolong_err", 32'(boot_err), 32'd1);
    chk("toolong_done", 32'(boot_done), 32'd0);
    chk("toolong_writes", 32'(wr_count), 32'd0);
    chk("toolong_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("toolong_in_ready", 32'(in_ready), 32'd0);

    // Zero length -> done with no writes.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    chk("zero_done_now", 32'(boot_done), 32'd1);
    chk("zero_writes", 32'(wr_count), 32'd0);
    chk("zero_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    // Full 1024-word image.
    do_reset();
    tb_sum = 8'h00;
    last_w = 16'h0000;
    send_byte(8'hA5, 1'b0);
    send_payload(8'h04, 1'b0);
    send_payload(8'h00, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i * 37) ^ 16'h5A01;
      send_payload(w[15:8], 1'b0);
      send_payload(w[7:0], 1'b0);
      last_w = w;
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_sum, 1'b0);
`endif
    wait_end(20);
    chk("full_writes", 32'(wr_count), 32'd1024);
    chk("full_seq_addr", 32'(seq_bad), 32'd0);
    chk("full_first_data", 32'(wr_data[0]), 32'h5A01);
    chk("full_last_addr", 32'(wr_addr[1023]), 32'h3FF);
    chk("full_last_data", 32'(wr_data[1023]), 32'(last_w));
    chk("full_done", 32'(boot_done), 32'd1);

    // Reset in the middle of a load, then a clean reload.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    for (int t = 0; t < 20; t++) begin
      if (wr_count >= 1) break;
      @(negedge CLK);
    end
    chk("midrst_first_write", 32'(wr_count), 32'd1);
    #3 RST = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_im_we", 32'(im_we), 32'd0);
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("midrst_done", 32'(boot_done), 32'd0);
    chk("midrst_err", 32'(boot_err), 32'd0);
    repeat (2) @(negedge CLK);
    wr_count = 0;
    ready_bad = 0;
    seq_bad = 0;
    #2 RST = 1'b1;
    @(negedge CLK);
    send_frame(1'b0, 8'h00);
    wait_end(20);
    check_two_words("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word address width (1024 words).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  8  serial byte stream from host.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port im_addr  output  ADDR_W  instruction-memory write address.
REQ-009 SHALL have port im_wdata  output  16  instruction word.
REQ-010 SHALL have port im_we  output  1  one-cycle write strobe.
REQ-011 SHALL have port cpu_rst_n  output  1  CPU reset, low holds CPU in reset.
REQ-012 SHALL have port boot_done  output  1  load completed successfully (sticky).
REQ-013 SHALL have port boot_err  output  1  load failed (sticky).

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR.
REQ-015 IDLE: accepts and discards any byte except SYNC_BYTE; SYNC_BYTE -> LEN_HI.
REQ-016 LEN_HI/LEN_LO: capture 16-bit word count N, big-endian; the next state follows REQ-017 to REQ-019.
REQ-017 N == 0 -> CHK if BOOT_CHECKSUM_EN is defined, else DONE.
REQ-018 N > 2**ADDR_W -> ERROR.
REQ-019 otherwise -> DATA_HI.
REQ-020 DATA_HI/DATA_LO: capture instruction word big-endian, then WRITE.
REQ-021 WRITE lasts exactly one cycle: im_we=1, im_addr=word index, im_wdata=assembled word; in_ready=0.
REQ-022 Word index starts at 0 and increments after each WRITE; after word N-1 -> CHK (macro on) or DONE (macro off).
REQ-023 in_ready SHALL be 1 in IDLE, LEN_*, DATA_*, CHK; 0 in WRITE, DONE, ERROR.
REQ-024 in_valid low SHALL stall any state indefinitely with no state change; there is no timeout.
REQ-025 DONE: cpu_rst_n=1, boot_done=1; absorbing until RST.
REQ-026 ERROR: cpu_rst_n=0, boot_err=1; absorbing until RST.
REQ-027 cpu_rst_n SHALL be 0 in every state except DONE.
REQ-028 im_we SHALL be 0 outside WRITE; im_addr/im_wdata are don't-care when im_we=0.
REQ-029 Index arithmetic SHALL be ADDR_W+1 bits; N == 2**ADDR_W SHALL be legal, last address 2**ADDR_W-1, no wrap.

Reset
REQ-030 RST low SHALL asynchronously force IDLE, index=0, N=0, checksum=0.
REQ-031 RST low SHALL asynchronously force im_we=0, cpu_rst_n=0, boot_done=0, boot_err=0, in_ready=0.
REQ-032 in_ready SHALL rise on the first CLK edge after RST deasserts.
REQ-033 RST asserted mid-load SHALL abort; memory contents already written are left unchanged.

Configuration
REQ-034 With BOOT_CHECKSUM_EN defined: 8-bit running sum (mod 256) of all length and data bytes, excluding SYNC_BYTE.
REQ-035 In CHK, one trailing byte is compared with the sum: equal -> DONE, else -> ERROR.
REQ-036 Without BOOT_CHECKSUM_EN: no CHK state, no checksum register, no trailing byte consumed.

Structure
REQ-037 State enum boot_state_t and constant BOOT_SYNC_DEFAULT SHALL live in the shared typedefs package.
REQ-038 One sub-module SHALL be natural: boot_byte_pack, assembling two handshaked bytes into a 16-bit word with hi/lo phase.
REQ-039 boot_loader SHALL drive the write port of the instruction Mem instance and the CPU reset; the CPU top ties inst-memory we/wdata/addr via a load-phase mux.

Verification
REQ-040 Sequence 0x00, 0x13, A5, 00 02, 12 34, AB CD (macro off) -> im_we pulses: addr0=0x1234, then addr1=0xABCD; then boot_done=1 and cpu_rst_n=1.
REQ-041 Same frame with macro on, checksum 0xC0 -> DONE; checksum 0xC1 -> boot_err=1, cpu_rst_n=0, in_ready=0.
REQ-042 A5, 04 01 with ADDR_W=10 -> ERROR, with no im_we ever asserted; A5, 04 00 + 1024 words -> last write at addr 0x3FF, then DONE.
REQ-043 A5, 00 00 (macro off) -> DONE immediately after LEN_LO, with zero im_we pulses.
REQ-044 Randomly deasserted in_valid during the frame of REQ-040 -> identical writes; in_ready=0 observed on every WRITE cycle.
REQ-045 RST pulsed low after first word written -> outputs reset asynchronously; a fresh full frame then loads correctly from addr 0.
